multi_digit_display: RTL

MULTI_DIGIT_DISPLAY -- requirements
Module: multi_digit_display

---
 rtl/multi_digit_display_pkg.sv | 45 ++++
 rtl/multi_digit_display_bcd_converter.sv | 83 ++++++++
 rtl/multi_digit_display.sv | 130 +++++++++++++
 3 files changed

// File: rtl/multi_digit_display_pkg.sv
// Shared constants and helpers for the multiplexed score display:
// glyph table, converter state encoding, half-width and saturation limits.
package multi_digit_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_S     = 7'b0010010;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_SHIFT,
        CONV_LAST
    } conv_state_t;

    function automatic int unsigned half_w(input int unsigned digits);
        return digits / 2;
    endfunction

    // Largest value a half of the display can show: 10^(digits/2)-1.
    function automatic int unsigned sat_max(input int unsigned digits);
        int unsigned v;
        v = 1;
        for (int unsigned i = 0; i < digits / 2; i++) v = v * 10;
        return v - 1;
    endfunction

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/multi_digit_display_bcd_converter.sv
// Iterative double-dabble binary-to-BCD converter; done pulses SCORE_W+1
// cycles after an accepted start, result saturates to all nines.
module bcd_converter
    import multi_digit_display_pkg::*;
#(
    parameter int unsigned SCORE_W    = 7,
    parameter int unsigned DIGITS_OUT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [SCORE_W-1:0]      bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*DIGITS_OUT-1:0] bcd
);
    localparam int unsigned W_DIG = (SCORE_W + 2) / 3;
    localparam int unsigned CNT_W = $clog2(SCORE_W + 1);
    localparam logic [31:0] SAT   = 32'(sat_max(2 * DIGITS_OUT));

    conv_state_t                          r_state;
    logic [CNT_W-1:0]                     r_cnt;
    logic [SCORE_W-1:0]                   r_sh;
    logic [4*W_DIG-1:0]                   r_work;
    logic                                 r_sat;
    logic                                 r_busy;
    logic                                 r_done;
    logic [4*DIGITS_OUT-1:0]              r_bcd;
    logic [4*W_DIG-1:0]                   w_adj;
    logic [4*(W_DIG+DIGITS_OUT)-1:0]      w_ext;

    always_comb begin
        w_adj = r_work;
        for (int unsigned i = 0; i < W_DIG; i++) begin
            if (r_work[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
        end
        w_ext = {{(4*DIGITS_OUT){1'b0}}, r_work};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= CONV_IDLE;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_work  <= '0;
            r_sat   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bcd   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                CONV_IDLE: begin
                    if (start) begin
                        r_state <= CONV_SHIFT;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_sh    <= bin;
                        r_work  <= '0;
                        r_sat   <= (32'(bin) > SAT);
                    end
                end
                CONV_SHIFT: begin
                    r_work <= {w_adj[4*W_DIG-2:0], r_sh[SCORE_W-1]};
                    r_sh   <= r_sh << 1;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(SCORE_W - 1)) r_state <= CONV_LAST;
                end
                default: begin
                    r_state <= CONV_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_bcd   <= r_sat ? {DIGITS_OUT{4'd9}} : w_ext[4*DIGITS_OUT-1:0];
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;

endmodule

// File: rtl/multi_digit_display.sv
// Multiplexed seven-segment score display: left half player A, right half
// player B or highscore, with leading-zero blanking and whole-display blink.
module multi_digit_display
    import multi_digit_display_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned SCORE_W      = 7,
    parameter int unsigned REFRESH_DIV  = 1024,
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] pA_score,
    input  logic [SCORE_W-1:0] pB_score,
    input  logic [SCORE_W-1:0] highscore,
    input  logic               highscore_disp,
    input  logic               blink_en,
    input  logic               lz_blank,
    output logic [6:0]         seg,
    output logic [DIGITS-1:0]  an
);
    localparam int unsigned HALF   = half_w(DIGITS);
    localparam int unsigned SLOT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W  = $clog2(DIGITS);
    localparam int unsigned FCNT_W = $clog2(BLINK_FRAMES + 1);

    logic [SLOT_W-1:0]   r_slot;
    logic [IDX_W-1:0]    r_idx;
    logic [FCNT_W-1:0]   r_fcnt;
    logic                r_blink_on;
    logic                r_hs_pend;
    logic                r_hs_mode;
    logic                r_res_new;
    logic [4*HALF-1:0]   r_bcd_l;
    logic [4*HALF-1:0]   r_bcd_r;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_an;

    logic                w_slot_wrap;
    logic                w_frame_start;
    logic [SCORE_W-1:0]  w_src_r;
    logic                w_busy_l, w_busy_r, w_done_l, w_done_r;
    logic [4*HALF-1:0]   w_conv_l, w_conv_r;
    logic                w_left;
    logic [IDX_W-1:0]    w_j;
    logic [4*HALF-1:0]   w_half;
    logic                w_nz_above;
    logic [6:0]          w_glyph;
    logic [DIGITS-1:0]   w_an_on;

    assign w_slot_wrap   = (r_slot == SLOT_W'(REFRESH_DIV - 1));
    assign w_frame_start = w_slot_wrap && (r_idx == IDX_W'(DIGITS - 1));
    assign w_src_r       = highscore_disp ? highscore : pB_score;
    assign w_an_on       = ~(DIGITS'(1) << r_idx);

    bcd_converter #(.SCORE_W(SCORE_W), .DIGITS_OUT(HALF)) u_conv_l (
        .clk(clk), .rst(rst), .start(w_frame_start), .bin(pA_score),
        .busy(w_busy_l), .done(w_done_l), .bcd(w_conv_l)
    );

    bcd_converter #(.SCORE_W(SCORE_W), .DIGITS_OUT(HALF)) u_conv_r (
        .clk(clk), .rst(rst), .start(w_frame_start), .bin(w_src_r),
        .busy(w_busy_r), .done(w_done_r), .bcd(w_conv_r)
    );

    always_comb begin
        w_left     = (r_idx >= IDX_W'(HALF));
        w_j        = w_left ? r_idx - IDX_W'(HALF) : r_idx;
        w_half     = w_left ? r_bcd_l : r_bcd_r;
        w_nz_above = 1'b0;
        for (int unsigned k = 0; k < HALF; k++) begin
            if (IDX_W'(k) >= w_j && w_half[4*k +: 4] != 4'd0) w_nz_above = 1'b1;
        end
        w_glyph = SEG_BLANK;
        if (r_hs_mode && w_left) begin
            if (r_idx == IDX_W'(HALF))          w_glyph = SEG_S;
            else if (r_idx == IDX_W'(HALF + 1)) w_glyph = SEG_H;
        end else if (!(lz_blank && w_j != '0 && !w_nz_above)) begin
            w_glyph = digit_glyph(w_half[4*w_j +: 4]);
        end
    end

    // Results and display mode move together at a frame start, so a frame
    // never mixes old and new digits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot     <= '0;
            r_idx      <= '0;
            r_fcnt     <= '0;
            r_blink_on <= 1'b1;
            r_hs_pend  <= 1'b0;
            r_hs_mode  <= 1'b0;
            r_res_new  <= 1'b0;
            r_bcd_l    <= '0;
            r_bcd_r    <= '0;
            r_seg      <= SEG_BLANK;
            r_an       <= '1;
        end else begin
            r_slot <= w_slot_wrap ? '0 : r_slot + SLOT_W'(1);
            if (w_slot_wrap) r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
            if (w_done_l || w_done_r) r_res_new <= 1'b1;
            if (w_frame_start) begin
                r_hs_pend <= highscore_disp;
                if (r_res_new && !(w_busy_l || w_busy_r)) begin
                    r_bcd_l   <= w_conv_l;
                    r_bcd_r   <= w_conv_r;
                    r_hs_mode <= r_hs_pend;
                    r_res_new <= 1'b0;
                end
            end
            if (!blink_en) begin
                r_fcnt     <= '0;
                r_blink_on <= 1'b1;
            end else if (w_frame_start) begin
                if (r_fcnt == FCNT_W'(BLINK_FRAMES - 1)) begin
                    r_fcnt     <= '0;
                    r_blink_on <= ~r_blink_on;
                end else begin
                    r_fcnt <= r_fcnt + FCNT_W'(1);
                end
            end
            r_seg <= w_glyph;
            r_an  <= r_blink_on ? w_an_on : '1;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule
